sample_player: RTL and testbench
================================

Name: sample_player

Overview:
- Synthesizable, parametrised multi-channel sample source.
- Replays a preloaded table of signed ADC-format samples into the demodulator datapath (e.g. the Costas loop `sigin`) at a programmable rate.
- Lets the team run file-derived stimulus on hardware, not only in simulation.
- Supports one-shot and looping playback, output-format selection, and restart/stop control.

Parameters:
- DATA_W, 14, bits per channel sample.
- N_CH, 1, channels per table word, packed channel 0 in LSBs.
- DEPTH, 1024, table entries (power of two). localparam ADDR_W = clog2(DEPTH).
- DIV_W, 16, width of rate divider.

Ports:
- CLK_IN  in  1  system clock (100 MHz).
- RESET  in  1  asynchronous, active-high reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  ADDR_W  table write address.
- wr_data  in  N_CH*DATA_W  table write data.
- cfg_len  in  ADDR_W+1  samples to play, 0..DEPTH.
- cfg_div  in  DIV_W  sample period minus one, in clocks.
- cfg_loop  in  1  1 = wrap continuously, 0 = one-shot.
- cfg_obin  in  1  1 = offset-binary output (MSB inverted), 0 = two's complement.
- start  in  1  begin/restart playback (pulse).
- stop  in  1  abort playback (pulse).
- sample_out  out  N_CH*DATA_W  current samples, held between updates.
- sample_vld  out  1  one-cycle pulse per new sample.
- busy  out  1  high while in PLAY.
- done  out  1  one-cycle pulse at one-shot completion.
- wrap  out  1  one-cycle pulse each loop wrap.

Behaviour:
- Reset (async): state IDLE. sample_out = 0, sample_vld = 0, busy = 0, done = 0, wrap = 0. Read address, divider counter and latched config all = 0. Table contents undefined.
- States: IDLE, PLAY.
  - IDLE -> PLAY on start when cfg_len != 0 and stop = 0.
  - start with cfg_len = 0 is ignored.
- Config latching: cfg_len, cfg_div, cfg_loop, cfg_obin are latched on the accepted start edge. Changes during PLAY have no effect until the next start.
  - cfg_len > DEPTH saturates to DEPTH.
- Latency: start accepted at edge T.
  - busy = 1 from T+1.
  - Address 0 is read at T+1 (1-cycle synchronous RAM).
  - sample_out updates and sample_vld pulses at edge T+2.
  - Sample k is presented at T+2+k*(cfg_div+1).
- Divider: counts 0..cfg_div. Address advances when the counter = cfg_div. cfg_div = 0 gives a new sample every clock.
- End of table: after address len-1 is issued:
  - Loop mode: next address = 0, and wrap pulses coincident with the sample_vld of sample 0 of the new pass.
  - One-shot mode: no further reads. Coincident with the final sample_vld, done = 1 and the state returns to IDLE; busy = 0 from the following cycle.
- Output hold: sample_out holds its last value in IDLE; it is never forced to 0 except by RESET.
- Format: when obin = 1, each channel's MSB is inverted independently at the output register. No other arithmetic.
- stop: PLAY -> IDLE at the next edge. The in-flight read is discarded (no sample_vld, no done).
- start during PLAY: restart from address 0 with newly latched config; timing as from IDLE.
- start and stop in the same cycle: stop wins.
- Writes:
  - Accepted in any state.
  - A read and a write to the same address in the same cycle return the OLD data.
  - Writes during PLAY to addresses not yet read are played on this pass.
- RESET mid-play: immediate return to reset values; table contents retained (RAM has no reset).

Decomposition:
- Package sample_player_pkg:
  - state enum {IDLE, PLAY};
  - default DATA_W/N_CH/DEPTH constants;
  - channel slice helper function (index -> bit range).
- Sub-module sp_dpram: simple dual-port RAM, one write port, one registered read port, width N_CH*DATA_W, depth DEPTH, no reset, inferable as BRAM.

Test Plan:
- One-shot, unit rate: N_CH=1. Load addr0..3 = {100, -200, 8191, -8192}; cfg_len=4, cfg_div=0, cfg_loop=0; start at T.
  -> sample_vld at T+2..T+5 with those values; done at T+5; busy 0 from T+6; sample_out holds -8192.
- Loop with divider: cfg_len=3, cfg_div=2, cfg_loop=1.
  -> sample_vld every 3 clocks, sequence 0,1,2,0,1,…; wrap on each vld of address 0 after the first pass; done never asserts.
- Offset binary, N_CH=2: word {ch1=-1, ch0=0}, cfg_obin=1.
  -> sample_out ch0 = 14'h2000, ch1 = 14'h1FFF.
- Control edge cases:
  - stop after 2 samples -> no further vld, no done, sample_out holds sample 1.
  - start+stop in the same cycle from IDLE -> stays IDLE.
  - start with cfg_len=0 -> ignored.
  - start mid-play -> restart at addr 0, first vld 2 cycles later.
- Boundaries:
  - cfg_len=DEPTH+1 -> plays exactly DEPTH samples.
  - Same-cycle write/read of addr 5 (old=7, new=9) -> outputs 7.
  - RESET asserted mid-play -> all outputs 0 asynchronously; after release, start replays the retained table.

Source files
------------

// File: rtl/sample_player_pkg.sv
// Shared types and defaults for the sample_player table replay source.
// Channel c of a packed table word occupies bits [ch_msb(c)-:DATA_W].
package sample_player_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 14;
    localparam int DEF_N_CH   = 1;
    localparam int DEF_DEPTH  = 1024;
    localparam int DEF_DIV_W  = 16;

    function automatic int ch_msb(input int ch, input int data_w);
        return ch * data_w + data_w - 1;
    endfunction

endpackage

// File: rtl/sp_dpram.sv
// Simple dual-port table RAM: one write port, one registered read port, no reset.
// A same-address read and write in one cycle returns the previous contents.
module sp_dpram #(
    parameter int WIDTH  = 14,
    parameter int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sample_player.sv
// Replays a preloaded table of signed ADC samples at a programmable rate.
// Pipeline: read issue -> RAM register -> formatted output register (2 cycles).
module sample_player
    import sample_player_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_CH   = DEF_N_CH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DIV_W  = DEF_DIV_W,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int W      = N_CH * DATA_W
) (
    input  logic              CLK_IN,
    input  logic              RESET,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W-1:0]      wr_data,
    input  logic [ADDR_W:0]   cfg_len,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_loop,
    input  logic              cfg_obin,
    input  logic              start,
    input  logic              stop,
    output logic [W-1:0]      sample_out,
    output logic              sample_vld,
    output logic              busy,
    output logic              done,
    output logic              wrap
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DEPTH);

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  rd_addr;
    logic [DIV_W-1:0]   div_cnt;
    logic [LEN_W-1:0]   len_q;
    logic [DIV_W-1:0]   div_q;
    logic               loop_q;
    logic               obin_q;
    logic               all_issued;
    logic               second_pass;
    logic               p1_vld;
    logic               p1_last;
    logic               p1_wrap;
    logic [W-1:0]       ram_q;
    logic [W-1:0]       fmt_word;
    logic               accept;
    logic               issue;
    logic               is_last;
    logic               div_tick;

    // stop outranks start; a zero-length start is ignored in every state
    assign accept   = start && !stop && (cfg_len != '0);
    assign div_tick = (div_cnt == div_q);
    assign is_last  = ({1'b0, rd_addr} == (len_q - LEN_W'(1)));
    assign issue    = (state == PLAY) && (div_cnt == '0) && !all_issued;
    assign busy     = (state == PLAY);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = PLAY;
            PLAY:    if (stop || (done && !accept)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Address/divider sequencing and config capture
    always_ff @(posedge CLK_IN or posedge RESET) begin
        if (RESET) begin
            rd_addr     <= '0;
            div_cnt     <= '0;
            len_q       <= '0;
            div_q       <= '0;
            loop_q      <= 1'b0;
            obin_q      <= 1'b0;
            all_issued  <= 1'b0;
            second_pass <= 1'b0;
        end else if (accept) begin
            len_q       <= (cfg_len > FULL_LEN) ? FULL_LEN : cfg_len;
            div_q       <= cfg_div;
            loop_q      <= cfg_loop;
            obin_q      <= cfg_obin;
            rd_addr     <= '0;
            div_cnt     <= '0;
            all_issued  <= 1'b0;
            second_pass <= 1'b0;
        end else if ((state == PLAY) && !stop) begin
            div_cnt <= div_tick ? '0 : div_cnt + DIV_W'(1);
            if (div_tick && !all_issued) begin
                if (is_last) begin
                    if (loop_q) begin
                        rd_addr     <= '0;
                        second_pass <= 1'b1;
                    end else begin
                        all_issued <= 1'b1;
                    end
                end else begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                end
            end
        end
    end

    sp_dpram #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (CLK_IN),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (issue),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    for (genvar g = 0; g < N_CH; g++) begin : g_fmt
        localparam int MSB = ch_msb(g, DATA_W);
        assign fmt_word[MSB -: DATA_W] = {ram_q[MSB] ^ obin_q, ram_q[MSB-1 -: DATA_W-1]};
    end

    // stop or a restart flushes whatever is still in flight
    always_ff @(posedge CLK_IN or posedge RESET) begin
        if (RESET) begin
            p1_vld     <= 1'b0;
            p1_last    <= 1'b0;
            p1_wrap    <= 1'b0;
            sample_out <= '0;
            sample_vld <= 1'b0;
            done       <= 1'b0;
            wrap       <= 1'b0;
        end else begin
            p1_vld  <= issue && !stop && !accept;
            p1_last <= is_last && !loop_q;
            p1_wrap <= second_pass && (rd_addr == '0);
            if (stop || accept) begin
                sample_vld <= 1'b0;
                done       <= 1'b0;
                wrap       <= 1'b0;
            end else begin
                sample_vld <= p1_vld;
                done       <= p1_vld && p1_last;
                wrap       <= p1_vld && p1_wrap;
                if (p1_vld) begin
                    sample_out <= fmt_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_sample_player.sv
// Directed bench for sample_player: per-cycle vector tables for one-shot and
// looping playback, plus hand-written sequences for control and boundary cases.
module tb_sample_player;

    localparam int DATA_W = 14;
    localparam int N_CH   = 2;
    localparam int DEPTH  = 16;
    localparam int DIV_W  = 8;
    localparam int W      = N_CH * DATA_W;

    logic          CLK_IN = 1'b0;
    logic          RESET;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [W-1:0]  wr_data;
    logic [4:0]    cfg_len;
    logic [DIV_W-1:0] cfg_div;
    logic          cfg_loop;
    logic          cfg_obin;
    logic          start;
    logic          stop;
    logic [W-1:0]  sample_out;
    logic          sample_vld;
    logic          busy;
    logic          done;
    logic          wrap;

    sample_player #(
        .DATA_W (DATA_W),
        .N_CH   (N_CH),
        .DEPTH  (DEPTH),
        .DIV_W  (DIV_W)
    ) dut (
        .CLK_IN     (CLK_IN),
        .RESET      (RESET),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cfg_len    (cfg_len),
        .cfg_div    (cfg_div),
        .cfg_loop   (cfg_loop),
        .cfg_obin   (cfg_obin),
        .start      (start),
        .stop       (stop),
        .sample_out (sample_out),
        .sample_vld (sample_vld),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK_IN = ~CLK_IN;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    logic [W-1:0] mirror [DEPTH];
    logic [W-1:0] exp_q [$];

    typedef struct {
        logic         start;
        logic         stop;
        logic         vld;
        logic         done;
        logic         wrap;
        logic         busy;
        logic [W-1:0] out;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(input logic s, input logic p, input logic v, input logic d,
                                input logic w, input logic b, input logic [W-1:0] o);
        vec_t r;
        r.start = s; r.stop = p; r.vld = v; r.done = d; r.wrap = w; r.busy = b; r.out = o;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge CLK_IN);
        #1;
    endtask

    task automatic wr(input int a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        mirror[a] = d;
    endtask

    task automatic cfg(input int len, input int dv, input logic lp, input logic ob);
        cfg_len = 5'(len); cfg_div = DIV_W'(dv); cfg_loop = lp; cfg_obin = ob;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic run_rows(input int lo, input int hi, input string tag);
        for (int i = lo; i <= hi; i++) begin
            start = tbl[i].start;
            stop  = tbl[i].stop;
            tick();
            start = 1'b0;
            stop  = 1'b0;
            check($sformatf("%s%0d_vld", tag, i - lo), 32'(sample_vld), 32'(tbl[i].vld));
            check($sformatf("%s%0d_done", tag, i - lo), 32'(done), 32'(tbl[i].done));
            check($sformatf("%s%0d_wrap", tag, i - lo), 32'(wrap), 32'(tbl[i].wrap));
            check($sformatf("%s%0d_busy", tag, i - lo), 32'(busy), 32'(tbl[i].busy));
            check($sformatf("%s%0d_out", tag, i - lo), 32'(sample_out), 32'(tbl[i].out));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nvld;
        int ndone;
        logic [W-1:0] w;
        logic [W-1:0] e;

        // one-shot, len 4, div 0: rows are the outputs after edges T..T+7
        tbl[0]  = mk(1, 0, 0, 0, 0, 1, 28'h0000000);
        tbl[1]  = mk(0, 0, 0, 0, 0, 1, 28'h0000000);
        tbl[2]  = mk(0, 0, 1, 0, 0, 1, 28'h0000064);
        tbl[3]  = mk(0, 0, 1, 0, 0, 1, 28'h0003F38);
        tbl[4]  = mk(0, 0, 1, 0, 0, 1, 28'h0001FFF);
        tbl[5]  = mk(0, 0, 1, 1, 0, 1, 28'h0002000);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 28'h0002000);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 28'h0002000);
        // loop, len 3, div 2: a sample every 3 clocks, wrap on the second pass, stop at T+16
        tbl[8]  = mk(1, 0, 0, 0, 0, 1, 28'h0002000);
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 28'h0002000);
        tbl[10] = mk(0, 0, 1, 0, 0, 1, 28'h0000064);
        tbl[11] = mk(0, 0, 0, 0, 0, 1, 28'h0000064);
        tbl[12] = mk(0, 0, 0, 0, 0, 1, 28'h0000064);
        tbl[13] = mk(0, 0, 1, 0, 0, 1, 28'h0003F38);
        tbl[14] = mk(0, 0, 0, 0, 0, 1, 28'h0003F38);
        tbl[15] = mk(0, 0, 0, 0, 0, 1, 28'h0003F38);
        tbl[16] = mk(0, 0, 1, 0, 0, 1, 28'h0001FFF);
        tbl[17] = mk(0, 0, 0, 0, 0, 1, 28'h0001FFF);
        tbl[18] = mk(0, 0, 0, 0, 0, 1, 28'h0001FFF);
        tbl[19] = mk(0, 0, 1, 0, 1, 1, 28'h0000064);
        tbl[20] = mk(0, 0, 0, 0, 0, 1, 28'h0000064);
        tbl[21] = mk(0, 0, 0, 0, 0, 1, 28'h0000064);
        tbl[22] = mk(0, 0, 1, 0, 0, 1, 28'h0003F38);
        tbl[23] = mk(0, 0, 0, 0, 0, 1, 28'h0003F38);
        tbl[24] = mk(0, 1, 0, 0, 0, 0, 28'h0003F38);
        tbl[25] = mk(0, 0, 0, 0, 0, 0, 28'h0003F38);

        RESET = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0;
        cfg(0, 0, 1'b0, 1'b0);
        tick();
        tick();
        check("rst_out", 32'(sample_out), 32'd0);
        check("rst_vld", 32'(sample_vld), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        RESET = 1'b0;
        tick();

        // table: 100, -200, 8191, -8192 on channel 0
        wr(0, 28'h0000064);
        wr(1, 28'h0003F38);
        wr(2, 28'h0001FFF);
        wr(3, 28'h0002000);

        cfg(4, 0, 1'b0, 1'b0);
        run_rows(0, 7, "oneshot");

        cfg(3, 2, 1'b1, 1'b0);
        run_rows(8, 25, "loop");

        // stop after two samples: nothing further, output holds sample 1
        cfg(4, 0, 1'b0, 1'b0);
        pulse_start();
        tick();
        tick();
        tick();
        check("stop_s1", 32'(sample_out), 32'h0003F38);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", 32'(busy), 32'd0);
        nvld = 0; ndone = 0;
        for (int i = 0; i < 6; i++) begin
            if (sample_vld) nvld++;
            if (done) ndone++;
            tick();
        end
        check("stop_no_vld", 32'(nvld), 32'd0);
        check("stop_no_done", 32'(ndone), 32'd0);
        check("stop_hold", 32'(sample_out), 32'h0003F38);

        // start and stop together from IDLE
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("ss_busy", 32'(busy), 32'd0);
        tick();
        tick();
        check("ss_vld", 32'(sample_vld), 32'd0);

        // zero-length start is ignored
        cfg(0, 0, 1'b0, 1'b0);
        pulse_start();
        check("len0_busy", 32'(busy), 32'd0);
        tick();
        tick();
        check("len0_vld", 32'(sample_vld), 32'd0);

        // restart mid-play: first new sample 2 cycles after the restart
        cfg(4, 0, 1'b0, 1'b0);
        pulse_start();
        tick();
        tick();
        tick();
        check("rs_pre", 32'(sample_out), 32'h0003F38);
        pulse_start();
        check("rs_t0_vld", 32'(sample_vld), 32'd0);
        check("rs_t0_busy", 32'(busy), 32'd1);
        tick();
        check("rs_t1_vld", 32'(sample_vld), 32'd0);
        tick();
        check("rs_t2_vld", 32'(sample_vld), 32'd1);
        check("rs_t2_out", 32'(sample_out), 32'h0000064);
        wait_idle("rs_idle");

        // offset binary on two channels: ch1 = -1, ch0 = 0
        wr(0, {14'h3FFF, 14'h0000});
        cfg(1, 0, 1'b0, 1'b1);
        pulse_start();
        tick();
        tick();
        check("obin_vld", 32'(sample_vld), 32'd1);
        check("obin_done", 32'(done), 32'd1);
        check("obin_ch0", 32'(sample_out[13:0]), 32'h2000);
        check("obin_ch1", 32'(sample_out[27:14]), 32'h1FFF);
        tick();
        check("obin_idle", 32'(busy), 32'd0);

        // over-length request plays exactly DEPTH samples
        for (int i = 0; i < DEPTH; i++) begin
            w = {14'($urandom_range(0, 16383)), 14'(i * 3 + 1)};
            wr(i, w);
            exp_q.push_back(w);
        end
        cfg(DEPTH + 1, 0, 1'b0, 1'b0);
        pulse_start();
        nvld = 0; ndone = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (sample_vld) begin
                nvld++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("depth_s%0d", nvld - 1), 32'(sample_out), 32'(e));
                end
            end
            if (done) ndone++;
        end
        check("depth_count", 32'(nvld), 32'(DEPTH));
        check("depth_done", 32'(ndone), 32'd1);
        check("depth_idle", 32'(busy), 32'd0);

        // same-cycle write/read of address 5 returns the old word
        wr(5, 28'd7);
        cfg(8, 0, 1'b0, 1'b0);
        pulse_start();
        for (int i = 0; i < 5; i++) tick();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 28'd9;
        tick();
        wr_en = 1'b0;
        mirror[5] = 28'd9;
        check("rw_s4", 32'(sample_out), 32'(mirror[4]));
        tick();
        check("rw_vld", 32'(sample_vld), 32'd1);
        check("rw_old", 32'(sample_out), 32'd7);
        wait_idle("rw_idle");
        pulse_start();
        for (int i = 0; i < 7; i++) tick();
        check("rw_new", 32'(sample_out), 32'd9);
        wait_idle("rw_idle2");

        // asynchronous reset mid-play, then replay of the retained table
        cfg(3, 0, 1'b1, 1'b0);
        pulse_start();
        for (int i = 0; i < 4; i++) tick();
        #2;
        RESET = 1'b1;
        #1;
        check("arst_out", 32'(sample_out), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_vld", 32'(sample_vld), 32'd0);
        tick();
        RESET = 1'b0;
        tick();
        cfg(3, 0, 1'b0, 1'b0);
        pulse_start();
        tick();
        tick();
        check("replay_s0", 32'(sample_out), 32'(mirror[0]));
        tick();
        check("replay_s1", 32'(sample_out), 32'(mirror[1]));
        wait_idle("replay_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
